// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM datapath: default widths and control FSM encoding.
package pwm_pkg;
    localparam int DEF_WIDTH_PERIOD = 16;
    localparam int DEF_WIDTH_DUTY   = 16;
    localparam int DEF_STEP_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RAMP = 2'd2
    } state_t;
endpackage

// File: rtl/ramp_step.sv
// Combinational saturating step of cur toward tgt by step; never overshoots tgt.
// Differences are formed one bit wider so neither direction can wrap.
module ramp_step #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [WIDTH-1:0]  tgt,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  nxt
);
    logic [WIDTH-1:0] step_n;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   gap_up;
    logic [WIDTH:0]   gap_dn;

    assign step_n = {{(WIDTH-STEP_W){1'b0}}, step};
    assign step_x = {1'b0, step_n};
    assign gap_up = {1'b0, tgt} - {1'b0, cur};
    assign gap_dn = {1'b0, cur} - {1'b0, tgt};

    always_comb begin
        nxt = tgt;
        if (cur < tgt) begin
            if (gap_up > step_x) nxt = cur + step_n;
        end else if (cur > tgt) begin
            if (gap_dn > step_x) nxt = cur - step_n;
        end
    end
endmodule

// File: rtl/pwm_duty_ramp.sv
// Retargets PWM period/duty on counter wrap, optionally ramping the duty by a fixed step per period.
// Outputs change only one clock after period_end_i; duty is always clamped to the applied period.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD,
    parameter int WIDTH_DUTY   = DEF_WIDTH_DUTY,
    parameter int STEP_W       = DEF_STEP_W,
    parameter logic [WIDTH_PERIOD-1:0] RESET_PERIOD = 16'hFFFF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [WIDTH_PERIOD-1:0] tgt_period_i,
    input  logic [WIDTH_DUTY-1:0]   tgt_duty_i,
    input  logic [STEP_W-1:0]       step_i,
    input  logic                    ramp_en_i,
    input  logic                    period_end_i,
    output logic [WIDTH_PERIOD-1:0] cfg_period_o,
    output logic [WIDTH_DUTY-1:0]   cfg_duty_o,
    output logic                    busy_o,
    output logic                    err_o
);
    state_t                  state;
    state_t                  state_next;
    logic [WIDTH_PERIOD-1:0] tgt_period;
    logic [WIDTH_DUTY-1:0]   tgt_duty;
    logic [STEP_W-1:0]       step_r;

    logic                    apply;
    logic [WIDTH_PERIOD-1:0] period_new;
    logic [WIDTH_DUTY-1:0]   duty_clamped;
    logic [WIDTH_DUTY-1:0]   duty_step;
    logic [WIDTH_DUTY-1:0]   duty_next;
    logic [WIDTH_DUTY-1:0]   load_duty;

    ramp_step #(
        .WIDTH  (WIDTH_DUTY),
        .STEP_W (STEP_W)
    ) u_ramp_step (
        .cur  (duty_clamped),
        .tgt  (tgt_duty),
        .step (step_r),
        .nxt  (duty_step)
    );

    // A pending retarget applies its period first; the old duty is clamped under it before stepping.
    always_comb begin
        apply        = period_end_i && (state != ST_IDLE);
        period_new   = (state == ST_PEND) ? tgt_period : cfg_period_o;
        duty_clamped = (cfg_duty_o > period_new) ? period_new : cfg_duty_o;
        duty_next    = (!ramp_en_i || (step_r == '0)) ? tgt_duty : duty_step;
        load_duty    = (tgt_duty_i > tgt_period_i) ? tgt_period_i : tgt_duty_i;

        state_next = state;
        if (apply) state_next = (duty_next == tgt_duty) ? ST_IDLE : ST_RAMP;
        if (load_i) state_next = ST_PEND;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            tgt_period   <= RESET_PERIOD;
            tgt_duty     <= '0;
            step_r       <= '0;
            cfg_period_o <= RESET_PERIOD;
            cfg_duty_o   <= '0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != ST_IDLE);
            if (apply) begin
                cfg_period_o <= period_new;
                cfg_duty_o   <= duty_next;
            end
            // The wrap above used the old target; the new one is captured for the next wrap.
            if (load_i) begin
                tgt_period <= tgt_period_i;
                tgt_duty   <= load_duty;
                step_r     <= step_i;
                err_o      <= (tgt_duty_i > tgt_period_i);
            end
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_pwm_duty_ramp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] tgt_period = '0;
    logic [15:0] tgt_duty = '0;
    logic [7:0]  step = '0;
    logic        ramp_en = 1'b0;
    logic        period_end = 1'b0;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;

    pwm_duty_ramp dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load),
        .tgt_period_i (tgt_period),
        .tgt_duty_i   (tgt_duty),
        .step_i       (step),
        .ramp_en_i    (ramp_en),
        .period_end_i (period_end),
        .cfg_period_o (cfg_period),
        .cfg_duty_o   (cfg_duty),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the PWM core should be seeing, derived from the rules in plain integers.
    int  m_period, m_duty, m_tp, m_td, m_step;
    bit  m_err, m_waiting, m_moving;

    always @(posedge clk or posedge rst) begin
        int d;
        if (rst) begin
            m_period = 65535; m_duty = 0; m_tp = 65535; m_td = 0; m_step = 0;
            m_err = 0; m_waiting = 0; m_moving = 0;
        end else begin
            if (period_end && (m_waiting || m_moving)) begin
                if (m_waiting) m_period = m_tp;
                d = (m_duty > m_period) ? m_period : m_duty;
                if (!ramp_en || m_step == 0) d = m_td;
                else if (d < m_td)           d = (d + m_step > m_td) ? m_td : d + m_step;
                else                         d = (d - m_step < m_td) ? m_td : d - m_step;
                m_duty    = d;
                m_waiting = 0;
                m_moving  = (d != m_td);
            end
            if (load) begin
                m_tp      = int'(tgt_period);
                m_td      = (tgt_duty > tgt_period) ? int'(tgt_period) : int'(tgt_duty);
                m_step    = int'(step);
                m_err     = (tgt_duty > tgt_period);
                m_waiting = 1;
                m_moving  = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_period", int'(cfg_period), m_period);
        chk("model_duty",   int'(cfg_duty),   m_duty);
        chk("model_busy",   int'(busy),       int'(m_waiting || m_moving));
        chk("model_err",    int'(err),        int'(m_err));
        chk("duty_le_period", int'(cfg_duty <= cfg_period), 1);
    end

    task automatic expect_out(input string name, input int p, input int d, input int b, input int e);
        chk({name, "_period"}, int'(cfg_period), p);
        chk({name, "_duty"},   int'(cfg_duty),   d);
        chk({name, "_busy"},   int'(busy),       b);
        chk({name, "_err"},    int'(err),        e);
    endtask

    task automatic cyc(input bit ld, input bit pe, input int p, input int d, input int s);
        @(negedge clk);
        load = ld; period_end = pe;
        tgt_period = 16'(p); tgt_duty = 16'(d); step = 8'(s);
        @(posedge clk);
        #1;
        load = 1'b0; period_end = 1'b0;
    endtask

    task automatic do_load(input int p, input int d, input int s);
        cyc(1'b1, 1'b0, p, d, s);
    endtask

    task automatic do_pe();
        cyc(1'b0, 1'b1, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 expect_out("reset", 65535, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Jump without ramp
        ramp_en = 1'b0;
        do_load(100, 40, 0);
        expect_out("jump_pend", 65535, 0, 1, 0);
        do_pe();
        expect_out("jump_done", 100, 40, 0, 0);

        // Ramp up from 0 by 16 toward 40
        do_load(100, 0, 0);
        do_pe();
        ramp_en = 1'b1;
        do_load(100, 40, 16);
        do_pe(); expect_out("up1", 100, 16, 1, 0);
        do_pe(); expect_out("up2", 100, 32, 1, 0);
        do_pe(); expect_out("up3", 100, 40, 0, 0);

        // Shrinking period clamps the duty before stepping down
        ramp_en = 1'b0;
        do_load(100, 80, 0);
        do_pe();
        ramp_en = 1'b1;
        do_load(50, 10, 30);
        do_pe(); expect_out("clamp1", 50, 20, 1, 0);
        do_pe(); expect_out("clamp2", 50, 10, 0, 0);

        // Duty above period: flagged and saturated, cleared by a legal load
        ramp_en = 1'b0;
        do_load(100, 120, 5);
        expect_out("err_set", 50, 10, 1, 1);
        do_pe(); expect_out("err_sat", 100, 100, 0, 1);
        do_load(100, 50, 0);
        expect_out("err_clr", 100, 100, 1, 0);
        do_pe(); expect_out("err_clr_pe", 100, 50, 0, 0);

        // Reload of identical targets, and wrap in IDLE
        do_load(100, 50, 0);
        expect_out("same_pend", 100, 50, 1, 0);
        do_pe(); expect_out("same_idle", 100, 50, 0, 0);
        do_pe(); expect_out("idle_pe", 100, 50, 0, 0);

        // Load coincident with wrap mid-ramp
        ramp_en = 1'b1;
        do_load(100, 90, 16);
        do_pe(); expect_out("co_ramp", 100, 66, 1, 0);
        cyc(1'b1, 1'b1, 100, 20, 10);
        expect_out("co_both", 100, 82, 1, 0);
        do_pe(); expect_out("co_after", 100, 72, 1, 0);
        for (int i = 0; i < 20 && busy; i++) do_pe();
        expect_out("co_final", 100, 20, 0, 0);

        // Asynchronous reset mid-ramp
        ramp_en = 1'b0;
        do_load(100, 0, 0);
        do_pe();
        ramp_en = 1'b1;
        do_load(100, 64, 16);
        do_pe(); do_pe();
        expect_out("pre_rst", 100, 32, 1, 0);
        #2 rst = 1'b1;
        #1 expect_out("async_rst", 65535, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_pe(); do_pe();
        expect_out("post_rst", 65535, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pwm_duty_ramp.md
PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 SHALL have parameter WIDTH_PERIOD, default 16: width of period values.
REQ-002 SHALL have parameter WIDTH_DUTY, default 16: width of duty values (equal to WIDTH_PERIOD).
REQ-003 SHALL have parameter STEP_W, default 8: width of ramp step.
REQ-004 SHALL have parameter RESET_PERIOD, default 16'hFFFF: cfg_period_o value after reset.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port load_i, input, 1: one-cycle pulse that captures the new targets.
REQ-008 SHALL have port tgt_period_i, input, WIDTH_PERIOD: target period.
REQ-009 SHALL have port tgt_duty_i, input, WIDTH_DUTY: target duty.
REQ-010 SHALL have port step_i, input, STEP_W: duty increment/decrement per PWM period.
REQ-011 SHALL have port ramp_en_i, input, 1: 1 = ramp the duty, 0 = jump to target.
REQ-012 SHALL have port period_end_i, input, 1: one-cycle pulse from the PWM core at counter wrap.
REQ-013 SHALL have port cfg_period_o, output, WIDTH_PERIOD: period fed to the PWM core.
REQ-014 SHALL have port cfg_duty_o, output, WIDTH_DUTY: duty fed to the PWM core.
REQ-015 SHALL have port busy_o, output, 1: high whenever state != IDLE.
REQ-016 SHALL have port err_o, output, 1: sticky flag, set when a load requests duty > period.

Function
REQ-017 SHALL implement FSM states IDLE, PEND and RAMP.
REQ-018 On load_i, SHALL register tgt_period, tgt_duty = min(tgt_duty_i, tgt_period_i) and step; next state is PEND.
REQ-019 SHALL set err_o on a load with tgt_duty_i > tgt_period_i, and clear it on a load with tgt_duty_i <= tgt_period_i.
REQ-020 SHALL change outputs only on a period_end_i cycle; outputs are registered and update one clk after the pulse.
REQ-021 PEND + period_end_i: SHALL set cfg_period_o = tgt_period; then apply the duty update rule; next state is RAMP if duty != target, else IDLE.
REQ-022 Duty update rule: if ramp_en_i=0 or step=0, SHALL set cfg_duty_o = tgt_duty directly.
REQ-023 Otherwise the duty SHALL move toward tgt_duty by step, saturating at tgt_duty (no overshoot); arithmetic is done WIDTH_DUTY+1 wide so there is no wrap at 0 or max.
REQ-024 RAMP + period_end_i: SHALL apply the duty update rule; transition to IDLE on the cycle the duty reaches tgt_duty.
REQ-025 If the current duty exceeds the newly applied period, SHALL first clamp duty to the period, then apply the rule, so cfg_duty_o <= cfg_period_o always holds.
REQ-026 load_i during RAMP: SHALL retarget and go to PEND; the ramp continues from the current cfg_duty_o.
REQ-027 load_i and period_end_i in the same cycle: SHALL process period_end with the old target first, capture the new target, and go to PEND.
REQ-028 load_i in IDLE with targets equal to the current outputs: SHALL go to PEND, then to IDLE at the next period_end with no output change.
REQ-029 period_end_i in IDLE: no effect.

Reset
REQ-030 While rst_i=1, asynchronously: cfg_period_o=RESET_PERIOD, cfg_duty_o=0, busy_o=0, err_o=0, state=IDLE, target registers = {RESET_PERIOD, 0}.
REQ-031 Reset asserted mid-ramp SHALL abort the ramp; after release, outputs stay at reset values until the next load.

Structure
REQ-032 The FSM state encoding and the default widths SHALL live in shared package pwm_pkg, used by pwm_unit and the top level.
REQ-033 The saturating step toward target SHALL be a sub-module ramp_step (combinational: cur, tgt, step -> next).
REQ-034 This block SHALL sit directly upstream of pwm_unit, fed from the control register; pwm_unit supplies period_end_i.

Verification
REQ-035 Reset, then load period=100, duty=40, ramp_en=0, then one period_end -> cfg_period_o=100, cfg_duty_o=40, busy_o 1->0.
REQ-036 Load duty=40, step=16, ramp_en=1 from duty 0 -> successive period_end give duty 16, 32, 40; IDLE after the third.
REQ-037 From duty 80/period 100, load period=50, duty=10, step=30 -> clamp to 50, then 20, then 10.
REQ-038 Load duty=120, period=100 -> err_o=1 and target duty 100; a later load of 50/100 clears err_o.
REQ-039 load_i coincident with period_end_i mid-ramp -> old-target step applied, state PEND, new target reached on later pulses.
REQ-040 rst_i asserted mid-ramp (duty 32) -> outputs go to RESET_PERIOD/0 immediately with no clock; busy_o=0.
